his_peak_finder: RTL
====================

HIS_PEAK_FINDER -- requirements
Module: his_peak_finder

Interface
REQ-001 Parameter NB, default 6, bin address width; NBINS = 2^NB bins per histogram.
REQ-002 Parameter CW, default 8, bin count width (unsigned).
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 res  input  1  reset, asynchronous, active-low.
REQ-005 acq_done  input  1  one-cycle pulse; the histogram in bank bank_sel is complete.
REQ-006 bank_sel  input  1  completed bank index from the histogram builder (hisNum).
REQ-007 thresh  input  CW  minimum peak count accepted as a target.
REQ-008 rd_en  output  1  bin read strobe to histogram RAM.
REQ-009 rd_bank  output  1  bank being read; latched bank_sel.
REQ-010 rd_addr  output  NB  bin address being read.
REQ-011 rd_data  input  CW  bin count; valid exactly one cycle after the rd_en/rd_addr edge.
REQ-012 peak_bin  output  NB  index of maximum bin.
REQ-013 peak_count  output  CW  count at peak_bin.
REQ-014 no_target  output  1  peak_count < thresh.
REQ-015 peak_valid  output  1  one-cycle pulse; result outputs updated.
REQ-016 busy  output  1  high from acq_done acceptance until peak_valid.
REQ-017 overrun  output  1  one-cycle pulse; acq_done arrived while busy.

Function
REQ-018 FSM states IDLE, READ, DRAIN, DONE; IDLE->READ on acq_done; READ->DRAIN after address NBINS-1 is issued; DRAIN->DONE after last rd_data is captured; DONE->IDLE unconditionally.
REQ-019 On acq_done in IDLE at edge T: latch bank_sel into rd_bank and thresh into an internal register; set rd_en=1, rd_addr=0.
REQ-020 READ: rd_addr SHALL increment by 1 per cycle, 0..NBINS-1, no gaps; rd_en SHALL drop at the edge after address NBINS-1 is presented.
REQ-021 Each captured rd_data SHALL be compared with the running max; strictly greater replaces max and index, so ties resolve to the lowest index.
REQ-022 Running max/index SHALL be cleared to 0 at acceptance, so an all-zero histogram yields peak_bin=0, peak_count=0.
REQ-023 peak_valid SHALL be high for exactly the cycle following edge T+NBINS+2; peak_bin, peak_count, no_target SHALL update at that same edge and hold until the next peak_valid.
REQ-024 no_target = (peak_count < latched thresh); peak_bin and peak_count SHALL still report the true maximum.
REQ-025 acq_done while busy: the pulse SHALL be ignored and overrun SHALL pulse for one cycle; the current scan SHALL continue unaffected.
REQ-026 acq_done in the DONE cycle SHALL be treated as overrun, not accepted.
REQ-027 Comparisons SHALL be unsigned CW-bit; no saturation or wrap is needed because no arithmetic is done on counts.

Reset
REQ-028 res low SHALL force IDLE and set every output to 0 (rd_en, rd_bank, rd_addr, peak_bin, peak_count, no_target, peak_valid, busy, overrun), regardless of the current state.
REQ-029 Reset mid-scan SHALL discard partial results; the first acq_done after reset release SHALL start a complete scan.

Structure
REQ-030 NB, CW, and the FSM state encodings SHALL be defined in the shared parameter header used by the histogram builder.
REQ-031 A single sub-module, his_max_tracker, SHALL hold the running max, the index, and the compare; the FSM and address counter SHALL be in the top level.

Verification
REQ-032 Single peak: bin 17 = 200, other bins = 3, thresh = 50 -> peak_bin = 17, peak_count = 200, no_target = 0, peak_valid at T+66 (NB = 6).
REQ-033 Tie: bins 5 and 40 = 90, other bins = 0 -> peak_bin = 5, peak_count = 90.
REQ-034 All-zero histogram, thresh = 1 -> peak_bin = 0, peak_count = 0, no_target = 1.
REQ-035 Edge bins: bin 63 = 255 -> peak_bin = 63; separately, bin 0 = 255 with all others 254 -> peak_bin = 0.
REQ-036 acq_done pulsed at T+10 and T+66 of a scan -> overrun pulses twice; exactly one peak_valid, with the first scan's result.
REQ-037 res asserted at T+30 -> all outputs 0 in the same cycle; a new acq_done after release -> full 64-read scan and correct result; rd_bank follows bank_sel = 1.

Source files
------------

// File: rtl/his_pkg.sv
// Shared histogram-block parameters: bin geometry, count width and peak-finder FSM encoding.
package his_pkg;

  localparam int HIS_NB = 6;
  localparam int HIS_CW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } his_state_e;

endpackage

// File: rtl/his_max_tracker.sv
// Running maximum of a stream of bin counts and the index of its first occurrence.
module his_max_tracker
  import his_pkg::*;
#(
  parameter int NB = HIS_NB,
  parameter int CW = HIS_CW
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr_i,
  input  logic          cap_i,
  input  logic [NB-1:0] cap_idx_i,
  input  logic [CW-1:0] cap_data_i,
  output logic [CW-1:0] max_count_o,
  output logic [NB-1:0] max_idx_o
);

  logic [CW-1:0] max_q, max_d;
  logic [NB-1:0] idx_q, idx_d;

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (clr_i) begin
      max_d = '0;
      idx_d = '0;
    end else if (cap_i && (cap_data_i > max_q)) begin
      max_d = cap_data_i;
      idx_d = cap_idx_i;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  assign max_count_o = max_q;
  assign max_idx_o   = idx_q;

endmodule

// File: rtl/his_peak_finder.sv
// Scans one completed histogram bank bin by bin and reports the peak bin, its count
// and whether it falls below the target threshold.
module his_peak_finder
  import his_pkg::*;
#(
  parameter int NB = HIS_NB,
  parameter int CW = HIS_CW
) (
  input  logic          clk,
  input  logic          res,
  input  logic          acq_done,
  input  logic          bank_sel,
  input  logic [CW-1:0] thresh,
  output logic          rd_en,
  output logic          rd_bank,
  output logic [NB-1:0] rd_addr,
  input  logic [CW-1:0] rd_data,
  output logic [NB-1:0] peak_bin,
  output logic [CW-1:0] peak_count,
  output logic          no_target,
  output logic          peak_valid,
  output logic          busy,
  output logic          overrun
);

  localparam logic [NB-1:0] LAST_ADDR = {NB{1'b1}};

  his_state_e    state_q, state_d;
  logic          rd_en_q, rd_en_d;
  logic          rd_bank_q, rd_bank_d;
  logic [NB-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0] thresh_q, thresh_d;
  logic          data_vld_q;
  logic [NB-1:0] cap_idx_q;
  logic [NB-1:0] peak_bin_q, peak_bin_d;
  logic [CW-1:0] peak_count_q, peak_count_d;
  logic          no_target_q, no_target_d;
  logic          peak_valid_q, peak_valid_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          trk_clr;
  logic [CW-1:0] trk_max;
  logic [NB-1:0] trk_idx;

  always_comb begin
    state_d      = state_q;
    rd_en_d      = rd_en_q;
    rd_bank_d    = rd_bank_q;
    rd_addr_d    = rd_addr_q;
    thresh_d     = thresh_q;
    peak_bin_d   = peak_bin_q;
    peak_count_d = peak_count_q;
    no_target_d  = no_target_q;
    peak_valid_d = 1'b0;
    busy_d       = busy_q;
    overrun_d    = acq_done && (state_q != ST_IDLE);
    trk_clr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acq_done) begin
          state_d   = ST_READ;
          rd_en_d   = 1'b1;
          rd_bank_d = bank_sel;
          rd_addr_d = '0;
          thresh_d  = thresh;
          busy_d    = 1'b1;
          trk_clr   = 1'b1;
        end
      end
      ST_READ: begin
        if (rd_addr_q == LAST_ADDR) begin
          rd_en_d = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      // One cycle covers the RAM read latency for the final address.
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        state_d      = ST_IDLE;
        peak_bin_d   = trk_idx;
        peak_count_d = trk_max;
        no_target_d  = (trk_max < thresh_q);
        peak_valid_d = 1'b1;
        busy_d       = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= ST_IDLE;
      rd_en_q      <= 1'b0;
      rd_bank_q    <= 1'b0;
      rd_addr_q    <= '0;
      thresh_q     <= '0;
      data_vld_q   <= 1'b0;
      cap_idx_q    <= '0;
      peak_bin_q   <= '0;
      peak_count_q <= '0;
      no_target_q  <= 1'b0;
      peak_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      rd_bank_q    <= rd_bank_d;
      rd_addr_q    <= rd_addr_d;
      thresh_q     <= thresh_d;
      data_vld_q   <= rd_en_q;
      cap_idx_q    <= rd_addr_q;
      peak_bin_q   <= peak_bin_d;
      peak_count_q <= peak_count_d;
      no_target_q  <= no_target_d;
      peak_valid_q <= peak_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  his_max_tracker #(
    .NB(NB),
    .CW(CW)
  ) u_max_tracker (
    .clk        (clk),
    .res        (res),
    .clr_i      (trk_clr),
    .cap_i      (data_vld_q),
    .cap_idx_i  (cap_idx_q),
    .cap_data_i (rd_data),
    .max_count_o(trk_max),
    .max_idx_o  (trk_idx)
  );

  assign rd_en      = rd_en_q;
  assign rd_bank    = rd_bank_q;
  assign rd_addr    = rd_addr_q;
  assign peak_bin   = peak_bin_q;
  assign peak_count = peak_count_q;
  assign no_target  = no_target_q;
  assign peak_valid = peak_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
